mem_arbiter: RTL and testbench

- Arbitrates one single-port 32-bit memory between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Uses a req/ack handshake with round-robin arbitration. Replaces fixed alternate-cycle time slicing.
- Each requester waits only when the memory is busy. Supports a registered memory read latency of 1..8 cycles.
- Sits between the fetch/load-store units and the shared memory.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin req/ack arbiter sharing one single-port memory between the fetch and data ports.
// Optional grant counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_ack,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_val,
    input  logic [DATA_W-1:0] mem_read_val
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       instr_grant_cnt,
    output logic [15:0]       data_grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = data port
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_write_val_q, mem_write_val_d;
    logic              mem_read_en_q, mem_read_en_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic              instr_ack_q, instr_ack_d;
    logic              data_ack_q, data_ack_d;
    logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              sel_data_s;
    logic              grant_fire_s;

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        we_d            = we_q;
        cnt_d           = cnt_q;
        mem_addr_d      = mem_addr_q;
        mem_write_val_d = mem_write_val_q;
        mem_read_en_d   = 1'b0;
        mem_write_en_d  = 1'b0;
        instr_ack_d     = 1'b0;
        data_ack_d      = 1'b0;
        instr_rdata_d   = instr_rdata_q;
        data_rdata_d    = data_rdata_q;
        sel_data_s      = 1'b0;
        grant_fire_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_req && data_req) begin
                    sel_data_s = ~last_grant_q;
                end else begin
                    sel_data_s = data_req;
                end
                if (instr_req || data_req) begin
                    grant_fire_s   = 1'b1;
                    grant_d        = sel_data_s;
                    last_grant_d   = sel_data_s;
                    we_d           = sel_data_s & data_we;
                    // Strobes are registered here so they are high exactly during ISSUE.
                    mem_read_en_d  = ~(sel_data_s & data_we);
                    mem_write_en_d = sel_data_s & data_we;
                    if (sel_data_s) begin
                        mem_addr_d      = data_addr;
                        mem_write_val_d = data_wdata;
                    end else begin
                        mem_addr_d      = instr_addr;
                        mem_write_val_d = mem_write_val_q;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    data_ack_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d   = 3'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    if (grant_q) begin
                        data_rdata_d = mem_read_val;
                        data_ack_d   = 1'b1;
                    end else begin
                        instr_rdata_d = mem_read_val;
                        instr_ack_d   = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            we_q            <= 1'b0;
            cnt_q           <= 3'd0;
            mem_addr_q      <= '0;
            mem_write_val_q <= '0;
            mem_read_en_q   <= 1'b0;
            mem_write_en_q  <= 1'b0;
            instr_ack_q     <= 1'b0;
            data_ack_q      <= 1'b0;
            instr_rdata_q   <= '0;
            data_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            we_q            <= we_d;
            cnt_q           <= cnt_d;
            mem_addr_q      <= mem_addr_d;
            mem_write_val_q <= mem_write_val_d;
            mem_read_en_q   <= mem_read_en_d;
            mem_write_en_q  <= mem_write_en_d;
            instr_ack_q     <= instr_ack_d;
            data_ack_q      <= data_ack_d;
            instr_rdata_q   <= instr_rdata_d;
            data_rdata_q    <= data_rdata_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_write_val = mem_write_val_q;
    assign mem_read_en   = mem_read_en_q;
    assign mem_write_en  = mem_write_en_q;
    assign instr_ack     = instr_ack_q;
    assign data_ack      = data_ack_q;
    assign instr_rdata   = instr_rdata_q;
    assign data_rdata    = data_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] instr_grant_cnt_q, instr_grant_cnt_d;
    logic [15:0] data_grant_cnt_q, data_grant_cnt_d;

    // Saturating per-port grant counters.
    always_comb begin
        instr_grant_cnt_d = instr_grant_cnt_q;
        data_grant_cnt_d  = data_grant_cnt_q;
        if (grant_fire_s && !sel_data_s && (instr_grant_cnt_q != 16'hFFFF)) begin
            instr_grant_cnt_d = instr_grant_cnt_q + 16'd1;
        end else begin
            instr_grant_cnt_d = instr_grant_cnt_q;
        end
        if (grant_fire_s && sel_data_s && (data_grant_cnt_q != 16'hFFFF)) begin
            data_grant_cnt_d = data_grant_cnt_q + 16'd1;
        end else begin
            data_grant_cnt_d = data_grant_cnt_q;
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_grant_cnt_q <= 16'd0;
            data_grant_cnt_q  <= 16'd0;
        end else begin
            instr_grant_cnt_q <= instr_grant_cnt_d;
            data_grant_cnt_q  <= data_grant_cnt_d;
        end
    end

    assign instr_grant_cnt = instr_grant_cnt_q;
    assign data_grant_cnt  = data_grant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic        instr_req, instr_ack, data_req, data_we, data_ack;
    logic [7:0]  instr_addr, data_addr, mem_addr;
    logic [31:0] instr_rdata, data_wdata, data_rdata, mem_write_val, mem_read_val;
    logic        mem_read_en, mem_write_en;

    logic        instr_req3, instr_ack3, data_ack3, mem_read_en3, mem_write_en3;
    logic [7:0]  instr_addr3, mem_addr3;
    logic [31:0] instr_rdata3, data_rdata3, mem_write_val3, mem_read_val3;
    logic        zero1 = 1'b0;
    logic [7:0]  zero8 = 8'h00;
    logic [31:0] zero32 = 32'h0;

    logic        bd_we, bd_sel;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem  [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] pipe3 [0:2];

`ifdef MEM_ARB_PERF_EN
    logic [15:0] instr_grant_cnt, data_grant_cnt, instr_grant_cnt3, data_grant_cnt3;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val)
`ifdef MEM_ARB_PERF_EN
        , .instr_grant_cnt(instr_grant_cnt), .data_grant_cnt(data_grant_cnt)
`endif
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .instr_req(instr_req3), .instr_addr(instr_addr3), .instr_ack(instr_ack3), .instr_rdata(instr_rdata3),
        .data_req(zero1), .data_we(zero1), .data_addr(zero8), .data_wdata(zero32),
        .data_ack(data_ack3), .data_rdata(data_rdata3),
        .mem_addr(mem_addr3), .mem_read_en(mem_read_en3), .mem_write_en(mem_write_en3),
        .mem_write_val(mem_write_val3), .mem_read_val(mem_read_val3)
`ifdef MEM_ARB_PERF_EN
        , .instr_grant_cnt(instr_grant_cnt3), .data_grant_cnt(data_grant_cnt3)
`endif
    );

    // Memory with one-cycle registered read, plus backdoor preload.
    always @(posedge clk) begin
        if (bd_we && !bd_sel) mem[bd_addr] <= bd_data;
        else if (mem_write_en) mem[mem_addr] <= mem_write_val;
        mem_read_val <= mem_read_en ? mem[mem_addr] : 32'h0;
    end

    // Memory with three-cycle registered read latency.
    always @(posedge clk) begin
        if (bd_we && bd_sel) mem3[bd_addr] <= bd_data;
        else if (mem_write_en3) mem3[mem_addr3] <= mem_write_val3;
        pipe3[0] <= mem_read_en3 ? mem3[mem_addr3] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_read_val3 = pipe3[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [7:0] a, input logic [31:0] d);
        bd_sel = sel; bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction; latency counted in cycles after the req-sampling edge.
    task automatic run_op(input logic is_data, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic [31:0] exp_other);
        int lat = 0;
        int rd_n = 0;
        int wr_n = 0;
        int other_acks = 0;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
        end else begin
            instr_req = 1'b1; instr_addr = addr;
        end
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_read_en) rd_n++;
            if (mem_write_en) wr_n++;
            if (k == 1) begin
                check_val("issue_addr", 32'(mem_addr), 32'(addr));
                if (we) check_val("issue_wval", mem_write_val, wd);
            end
            if (is_data ? instr_ack : data_ack) other_acks++;
            if (is_data ? data_ack : instr_ack) lat = k;
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        check_val("ack_latency", 32'(lat), 32'(exp_lat));
        check_val("read_strobes", 32'(rd_n), we ? 32'd0 : 32'd1);
        check_val("write_strobes", 32'(wr_n), we ? 32'd1 : 32'd0);
        check_val("other_ack", 32'(other_acks), 32'd0);
        if (!we) check_val("rdata", is_data ? data_rdata : instr_rdata, exp_rd);
        check_val("other_rdata", is_data ? instr_rdata : data_rdata, exp_other);
        @(negedge clk);
        check_val("ack_pulse", 32'({instr_ack, data_ack}), 32'd0);
    endtask

    initial begin
        int n;
        int lat;
        int rd_n;
        int both;
        int dbl;
        logic prev_i, prev_d;
        logic [3:0] seq;

        reset = 1'b1;
        instr_req = 1'b0; instr_addr = 8'h00; data_req = 1'b0; data_we = 1'b0;
        data_addr = 8'h00; data_wdata = 32'h0; instr_req3 = 1'b0; instr_addr3 = 8'h00;
        bd_we = 1'b0; bd_sel = 1'b0; bd_addr = 8'h00; bd_data = 32'h0;
        @(negedge clk);
        preload(1'b0, 8'h10, 32'hDEADBEEF);
        preload(1'b1, 8'h05, 32'hA5A5A5A5);
        check_val("reset_outputs", 32'({instr_ack, data_ack, mem_read_en, mem_write_en}), 32'd0);
        check_val("reset_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fetch, write, then read back.
        run_op(1'b0, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 32'h0);
        run_op(1'b1, 1'b1, 8'h20, 32'h12345678, 2, 32'h0, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 8'h20, 32'h0, 3, 32'h12345678, 32'hDEADBEEF);

        // Both ports request continuously from reset.
        do_reset();
        instr_req = 1'b1; instr_addr = 8'h10;
        data_req = 1'b1; data_we = 1'b0; data_addr = 8'h20;
        n = 0; rd_n = 0; both = 0; dbl = 0; seq = 4'b0000; prev_i = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (mem_read_en) rd_n++;
            if (instr_ack && data_ack) both++;
            if ((instr_ack && prev_i) || (data_ack && prev_d)) dbl++;
            prev_i = instr_ack; prev_d = data_ack;
            if (instr_ack) begin seq[n] = 1'b0; n++; end
            else if (data_ack) begin seq[n] = 1'b1; n++; end
        end
        instr_req = 1'b0; data_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_read_en) rd_n++;
            if (instr_ack || data_ack) n++;
        end
        check_val("rr_ack_count", 32'(n), 32'd4);
        check_val("rr_order", 32'(seq), 32'(4'b1010));
        check_val("rr_reads", 32'(rd_n), 32'd4);
        check_val("rr_both_ack", 32'(both), 32'd0);
        check_val("rr_ack_width", 32'(dbl), 32'd0);
        check_val("rr_instr_rdata", instr_rdata, 32'hDEADBEEF);
        check_val("rr_data_rdata", data_rdata, 32'h12345678);

        // Reset during WAIT.
        instr_req = 1'b1; instr_addr = 8'h10;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("rst_strobes_acks", 32'({instr_ack, data_ack, mem_read_en, mem_write_en}), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_wval", mem_write_val, 32'h0);
        check_val("rst_instr_rdata", instr_rdata, 32'h0);
        check_val("rst_data_rdata", data_rdata, 32'h0);
        instr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (instr_ack || data_ack || mem_read_en) n++;
        end
        check_val("rst_no_ack", 32'(n), 32'd0);
        run_op(1'b1, 1'b0, 8'h20, 32'h0, 3, 32'h12345678, 32'h0);

        // RD_LAT=3 fetch.
        instr_req3 = 1'b1; instr_addr3 = 8'h05;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (instr_ack3) lat = k;
        end
        instr_req3 = 1'b0;
        check_val("lat3_latency", 32'(lat), 32'd5);
        check_val("lat3_rdata", instr_rdata3, 32'hA5A5A5A5);
        @(negedge clk);
        check_val("lat3_ack_pulse", 32'(instr_ack3), 32'd0);

`ifdef MEM_ARB_PERF_EN
        do_reset();
        run_op(1'b0, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 32'h0);
        run_op(1'b0, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 32'h0);
        run_op(1'b0, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 32'h0);
        run_op(1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 2, 32'h0, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 8'h30, 32'h0, 3, 32'hCAFEF00D, 32'hDEADBEEF);
        check_val("perf_instr_cnt", 32'(instr_grant_cnt), 32'd3);
        check_val("perf_data_cnt", 32'(data_grant_cnt), 32'd2);
        force u_dut.data_grant_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.data_grant_cnt_q;
        run_op(1'b1, 1'b1, 8'h31, 32'h0BADF00D, 2, 32'h0, 32'hDEADBEEF);
        check_val("perf_data_sat", 32'(data_grant_cnt), 32'h0000FFFF);
        check_val("perf_instr_hold", 32'(instr_grant_cnt), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
